data_mem: RTL and testbench
===========================

# data_mem

Synchronous data-memory responder that services load/store requests issued by the pipeline's memory-access stage. It holds a word-organised RAM, accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, and returns one response pulse. It raises a stall request to the pipeline while an access is outstanding. It sits beside the memory-access stage, on the far end of that stage's memory port.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two; ADDR_W = log2(DEPTH_WORDS).
- WAIT_CYCLES, 2: wait states between accept and response; legal range 0..15.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_wdata  input  32  store data.
- req_sel  input  4  byte-lane enables; sel[i] covers bits [8i+7:8i].
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  load data; unselected lanes zero; zero for stores and errors.
- resp_err  output  1  request rejected (valid only with resp_valid).
- stall_o  output  1  pipeline stall request.

## Operation
- States: IDLE, BUSY, RESP. Encoding is free.
- IDLE: req_ready = 1. On req_valid, latch we/addr/wdata/sel and load the wait counter with WAIT_CYCLES. Go to BUSY, or go straight to RESP when WAIT_CYCLES = 0.
- BUSY: req_ready = 0. The counter decrements each cycle. At counter = 1, the next state is RESP.
- Commit: on the edge entering RESP, a store writes only the selected lanes of word addr[ADDR_W+1:2]. A load captures that word, with unselected lanes zeroed, into the resp_rdata register.
- Error: raised if latched addr[31:ADDR_W+2] ≠ 0 (out of range) or sel = 4'b0000. On error, no RAM write occurs, rdata = 0 and resp_err = 1.
- RESP: resp_valid = 1 for exactly one cycle with no backpressure. req_ready = 0. The next state is always IDLE.
- stall_o = (IDLE & req_valid) | BUSY. It is low in RESP, so the pipeline advances in the response cycle.
- Request inputs are don't-care outside the accept cycle; the requester need not hold them.
- Only one request is outstanding at a time. Peak throughput is one request per WAIT_CYCLES + 2 cycles.
- RAM contents are not cleared by reset and are undefined at power-up.

## Timing
- Accept: the edge at the end of cycle T where IDLE & req_valid.
- Commit: the edge at the end of cycle T + WAIT_CYCLES.
- Response: resp_valid high in cycle T + WAIT_CYCLES + 1. Examples: WAIT_CYCLES = 2 gives T+3; WAIT_CYCLES = 0 gives T+1.
- Earliest next accept is cycle T + WAIT_CYCLES + 2.
- Reset, while rst is asserted:
  - state = IDLE, req_ready = 0, stall_o = 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
- Reset, first cycle after rst deasserts: req_ready = 1.
- Reset mid-operation: a request in BUSY is dropped and no store is committed. A reset in the RESP cycle suppresses the pulse; a commit already made stands.
- Store followed by load to the same word: the load returns the stored value, because commits are strictly ordered.
- Boundary addresses: the highest word, byte address DEPTH_WORDS*4 − 4, is legal. Byte address DEPTH_WORDS*4 is an error.
- resp_rdata and resp_err hold their values after the pulse until the next RESP. They are only meaningful with resp_valid.

## Test plan
- Reset, WAIT_CYCLES = 2:
  - Stimulus: hold rst for 3 cycles with req_valid = 1.
  - Required: req_ready, stall_o and resp_valid are all 0 during reset; req_ready = 1 on the first cycle after.
- Full-word store/load, WAIT_CYCLES = 2:
  - Stimulus: store 0xDEADBEEF to 0x0000_0010 with sel = 4'hF, then a load from 0x10.
  - Required: each resp_valid arrives 3 cycles after its accept; the load returns 0xDEADBEEF; stall_o is high for exactly 3 cycles per access.
- Byte lanes:
  - Stimulus: over word 0x11223344 at 0x20, store 0xAABBCCDD with sel = 4'b0101, then load with sel = 4'hF, then load with sel = 4'b0010.
  - Required: the full load returns 0x11BB33DD; the sel = 4'b0010 load returns 0x00003300.
- Errors, DEPTH_WORDS = 1024:
  - Stimulus: store to 0x0000_1000, then load from 0x0000_0FFC, then a request with sel = 0.
  - Required: the 0x1000 store gets resp_err = 1 and leaves RAM unchanged; the 0xFFC load succeeds; sel = 0 gets resp_err = 1 with rdata = 0.
- Zero wait, WAIT_CYCLES = 0:
  - Stimulus: hold req_valid high continuously with 4 back-to-back loads.
  - Required: every response arrives at T+1 and accepts occur every 2 cycles, for 4 responses in 8 cycles.
- Reset mid-BUSY, WAIT_CYCLES = 3:
  - Stimulus: store 0x12345678 to 0x40 over old value 0x0; assert rst in cycle T+2 for one cycle; then load 0x40.
  - Required: no resp_valid for the store; the later load returns 0x00000000.

Source files
------------

// File: rtl/data_mem_if.sv
// Request/response bus between the memory-access stage (master) and data_mem (slave).
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_sel,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_sel,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem.sv
// Word-organised data RAM answering one load/store at a time after WAIT_CYCLES wait states,
// with a stall request to the pipeline while an access is outstanding.
module data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  mem_bus,
    output logic       stall_o
);
    localparam int unsigned AddrW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  sel_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic             accept, commit;
    logic             cur_we, cur_err;
    logic [31:0]      cur_addr, cur_wdata, lane_mask;
    logic [3:0]       cur_sel;
    logic [AddrW-1:0] cur_idx;

    // With zero wait states the commit happens on the accept edge, so use the live request.
    always_comb begin
        accept    = (state_q == StIdle) && mem_bus.req_valid;
        cur_we    = accept ? mem_bus.req_we    : we_q;
        cur_addr  = accept ? mem_bus.req_addr  : addr_q;
        cur_wdata = accept ? mem_bus.req_wdata : wdata_q;
        cur_sel   = accept ? mem_bus.req_sel   : sel_q;
        cur_idx   = cur_addr[AddrW+1:2];
        cur_err   = ((cur_addr >> (AddrW + 2)) != 32'd0) || (cur_sel == 4'b0000);
        for (int i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{cur_sel[i]}};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (mem_bus.req_valid) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? StResp : StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        commit = (state_d == StResp) && (state_q != StResp) && !rst;
        if (commit) begin
            err_d   = cur_err;
            rdata_d = (!cur_we && !cur_err) ? (mem_q[cur_idx] & lane_mask) : 32'd0;
        end
    end

    always_comb begin
        mem_bus.req_ready  = !rst && (state_q == StIdle);
        mem_bus.resp_valid = !rst && (state_q == StResp);
        mem_bus.resp_rdata = rst ? 32'd0 : rdata_q;
        mem_bus.resp_err   = !rst && err_q;
        stall_o            = !rst && (accept || (state_q == StBusy));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            sel_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= mem_bus.req_we;
                addr_q  <= mem_bus.req_addr;
                wdata_q <= mem_bus.req_wdata;
                sel_q   <= mem_bus.req_sel;
            end
        end
    end

    // RAM has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_sel[i]) mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: three instances (2, 0 and 3 wait states) against a
// byte-level reference memory model.
module tb_data_mem;
    localparam int unsigned W0 = 2;
    localparam int unsigned W1 = 0;
    localparam int unsigned W2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    int          cur = 0;
    logic        g_rst = 1'b1;
    logic        d_rst = 1'b0;
    logic        d_valid = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [3:0]  d_sel = 4'd0;

    logic rst0, rst1, rst2, s0, s1, s2;
    assign rst0 = g_rst || (d_rst && cur == 0);
    assign rst1 = g_rst || (d_rst && cur == 1);
    assign rst2 = g_rst || (d_rst && cur == 2);

    data_mem_if if0 ();
    data_mem_if if1 ();
    data_mem_if if2 ();

    assign if0.req_valid = d_valid && (cur == 0);
    assign if1.req_valid = d_valid && (cur == 1);
    assign if2.req_valid = d_valid && (cur == 2);
    assign if0.req_we = d_we;       assign if1.req_we = d_we;       assign if2.req_we = d_we;
    assign if0.req_addr = d_addr;   assign if1.req_addr = d_addr;   assign if2.req_addr = d_addr;
    assign if0.req_wdata = d_wdata; assign if1.req_wdata = d_wdata; assign if2.req_wdata = d_wdata;
    assign if0.req_sel = d_sel;     assign if1.req_sel = d_sel;     assign if2.req_sel = d_sel;

    data_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst(rst0), .mem_bus(if0), .stall_o(s0));
    data_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst(rst1), .mem_bus(if1), .stall_o(s1));
    data_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W2)) u_dut2 (
        .clk(clk), .rst(rst2), .mem_bus(if2), .stall_o(s2));

    logic        o_ready, o_rvalid, o_err, o_stall;
    logic [31:0] o_rdata;
    always_comb begin
        o_ready = if0.req_ready; o_rvalid = if0.resp_valid; o_err = if0.resp_err;
        o_rdata = if0.resp_rdata; o_stall = s0;
        case (cur)
            1: begin
                o_ready = if1.req_ready; o_rvalid = if1.resp_valid; o_err = if1.resp_err;
                o_rdata = if1.resp_rdata; o_stall = s1;
            end
            2: begin
                o_ready = if2.req_ready; o_rvalid = if2.resp_valid; o_err = if2.resp_err;
                o_rdata = if2.resp_rdata; o_stall = s2;
            end
            default: ;
        endcase
    end

    // Reference memory: data plus per-byte "written" flags, one copy per instance.
    logic [31:0] ref_mem [3][1024];
    logic [3:0]  ref_bv  [3][1024];

    function automatic int wait_of(input int d);
        case (d)
            0: return int'(W0);
            1: return int'(W1);
            default: return int'(W2);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input bit hold, output bit got,
                        output logic [31:0] rdata, output bit err, output int lat,
                        output int stalls, output bit stall_resp, output int acc_c,
                        output int resp_c);
        @(negedge clk);
        d_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_sel = sel;
        #1;
        chk("accept_ready", 32'(o_ready), 32'd1);
        stalls = int'(o_stall);
        acc_c = cyc; resp_c = 0; got = 1'b0; lat = 0; rdata = '0; err = 1'b0;
        stall_resp = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            d_valid = hold; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
            d_sel = 4'($urandom);
            #1;
            if (o_rvalid) begin
                got = 1'b1; lat = k; rdata = o_rdata; err = o_err; resp_c = cyc;
                stall_resp = o_stall;
            end else begin
                stalls += int'(o_stall);
            end
        end
    endtask

    task automatic req_chk(input string tag, input int d, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input bit hold, output logic [31:0] rdata,
                           output int acc_c, output int resp_c);
        bit          got, err, e, known, sr;
        int          lat, stalls;
        logic [9:0]  idx;
        logic [31:0] mask, exp;
        cur = d;
        e = (addr >= 32'h1000) || (sel == 4'b0000);
        idx = addr[11:2];
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{sel[i]}};
        known = ((ref_bv[d][idx] & sel) == sel);
        exp = (we || e) ? 32'd0 : (ref_mem[d][idx] & mask);
        xact(we, addr, wdata, sel, hold, got, rdata, err, lat, stalls, sr, acc_c, resp_c);
        chk({tag, "/resp_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "/latency"}, lat, wait_of(d) + 1);
            chk({tag, "/stall_cycles"}, stalls, wait_of(d) + 1);
            chk({tag, "/stall_in_resp"}, 32'(sr), 32'd0);
            chk({tag, "/err"}, 32'(err), 32'(e));
            if (we || e || known) chk({tag, "/rdata"}, rdata, exp);
        end
        if (we && !e) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    ref_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
                    ref_bv[d][idx][i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int          a_c, r_c, first_acc, last_resp;
        bit          seen;
        for (int d = 0; d < 3; d++) for (int w = 0; w < 1024; w++) ref_bv[d][w] = 4'd0;

        // Reset held 3 cycles with a pending request on the 2-wait instance.
        cur = 0; d_valid = 1'b1; d_sel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_ready", 32'(o_ready), 32'd0);
            chk("rst_stall", 32'(o_stall), 32'd0);
            chk("rst_rvalid", 32'(o_rvalid), 32'd0);
            chk("rst_rdata", o_rdata, 32'd0);
            chk("rst_err", 32'(o_err), 32'd0);
        end
        g_rst = 1'b0; d_valid = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_ready", 32'(o_ready), 32'd1);

        // Full-word store/load.
        req_chk("st_word", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, a_c, r_c);
        req_chk("ld_word", 0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, a_c, r_c);
        chk("ld_word_val", rd, 32'hDEADBEEF);

        // Byte lanes.
        req_chk("st_base", 0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, rd, a_c, r_c);
        req_chk("st_lanes", 0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd, a_c, r_c);
        req_chk("ld_full", 0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, rd, a_c, r_c);
        chk("ld_full_val", rd, 32'h11BB33DD);
        req_chk("ld_lane1", 0, 1'b0, 32'h20, 32'h0, 4'b0010, 1'b0, rd, a_c, r_c);
        chk("ld_lane1_val", rd, 32'h00003300);

        // Errors and boundary addresses.
        req_chk("st_w0", 0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, 1'b0, rd, a_c, r_c);
        req_chk("st_oor", 0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b0, rd, a_c, r_c);
        req_chk("ld_w0", 0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, rd, a_c, r_c);
        chk("ld_w0_unchanged", rd, 32'h55AA55AA);
        req_chk("st_top", 0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 1'b0, rd, a_c, r_c);
        req_chk("ld_top", 0, 1'b0, 32'hFFC, 32'h0, 4'hF, 1'b0, rd, a_c, r_c);
        chk("ld_top_val", rd, 32'hCAFEF00D);
        req_chk("sel0", 0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, rd, a_c, r_c);

        // Randomised traffic over words 64..127, with some out-of-range and sel=0 requests.
        for (int w = 64; w < 128; w++)
            req_chk("rnd_fill", 0, 1'b1, 32'(w * 4), $urandom, 4'hF, 1'b0, rd, a_c, r_c);
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = 32'((64 + $urandom_range(0, 63)) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'h1000 | ($urandom << 13);
            req_chk("rnd", 0, 1'($urandom), a, $urandom, 4'($urandom_range(0, 15)), 1'b0,
                    rd, a_c, r_c);
        end

        // Zero wait states: back-to-back loads with req_valid held high.
        for (int w = 0; w < 4; w++)
            req_chk("zw_fill", 1, 1'b1, 32'(w * 4), 32'hA5000000 | 32'(w), 4'hF, 1'b0,
                    rd, a_c, r_c);
        first_acc = 0; last_resp = 0;
        for (int w = 0; w < 4; w++) begin
            req_chk("zw_ld", 1, 1'b0, 32'(w * 4), 32'h0, 4'hF, 1'b1, rd, a_c, r_c);
            if (w == 0) first_acc = a_c;
            last_resp = r_c;
        end
        @(negedge clk); d_valid = 1'b0;
        chk("zw_span", last_resp - first_acc + 1, 8);

        // Reset during BUSY on the 3-wait instance drops the store.
        req_chk("mb_init", 2, 1'b1, 32'h40, 32'h0, 4'hF, 1'b0, rd, a_c, r_c);
        cur = 2;
        @(negedge clk);
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_sel = 4'hF;
        @(negedge clk); d_valid = 1'b0;
        @(negedge clk); d_rst = 1'b1; #1;
        chk("mb_rst_stall", 32'(o_stall), 32'd0);
        seen = o_rvalid;
        @(negedge clk); d_rst = 1'b0; #1;
        chk("mb_ready_after", 32'(o_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            if (o_rvalid) seen = 1'b1;
            @(negedge clk); #1;
        end
        chk("mb_no_resp", 32'(seen), 32'd0);
        req_chk("mb_ld", 2, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, rd, a_c, r_c);
        chk("mb_ld_val", rd, 32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
